// File: rtl/net2axis_sink.sv
// -----------------------------------------------------------------------------
// net2axis_sink
//
// AXI4-Stream packet sink. It consumes every beat it accepts and checks them.
// It counts completed (TLAST-terminated) packets and accepted bytes. It raises
// DONE once C_NUM_PACKETS packets have been received, and then refuses all
// further traffic until reset. TREADY is held high, or it is throttled by a
// free-running 16-bit Fibonacci LFSR when C_BACKPRESSURE = 1.
//
// Optional build macro:
//   NET2AXIS_SINK_CHECK_EN - enables the protocol checker that drives ERROR
//                            and ERR_CODE. When the macro is undefined, both
//                            outputs are tied to zero and no checker logic
//                            exists.
//
// Parameters:
//   C_TDATA_WIDTH   TDATA width in bits (multiple of 8, 8..512)
//   C_NUM_PACKETS   packets accepted before DONE (1 .. 2^32-1)
//   C_BACKPRESSURE  0: TREADY high outside FIN, 1: TREADY = lfsr[0]
//   C_LFSR_SEED     nonzero 16-bit LFSR reset value
//
// Ports:
//   ACLK            clock, rising edge
//   ARESET          asynchronous active-high reset
//   S_AXIS_TVALID   upstream beat valid
//   S_AXIS_TDATA    beat data (only observed by the stability checker)
//   S_AXIS_TKEEP    byte qualifiers
//   S_AXIS_TLAST    last beat of a packet
//   S_AXIS_TREADY   sink ready (registered)
//   DONE            C_NUM_PACKETS packets received (registered, sticky)
//   PKT_COUNT       completed packets, wraps modulo 2^32
//   BYTE_COUNT      accepted bytes (popcount of TKEEP), wraps modulo 2^32
//   ERROR           OR of ERR_CODE (registered, sticky)
//   ERR_CODE        [0] stability, [1] TKEEP zero/non-contiguous,
//                   [2] partial TKEEP on a non-last beat (sticky)
// -----------------------------------------------------------------------------
module net2axis_sink #(
  parameter int unsigned C_TDATA_WIDTH  = 32,
  parameter logic [31:0] C_NUM_PACKETS  = 32'd1,
  parameter int unsigned C_BACKPRESSURE = 0,
  parameter logic [15:0] C_LFSR_SEED    = 16'hACE1
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         S_AXIS_TVALID,
  input  logic [C_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                         S_AXIS_TLAST,
  output logic                         S_AXIS_TREADY,
  output logic                         DONE,
  output logic [31:0]                  PKT_COUNT,
  output logic [31:0]                  BYTE_COUNT,
  output logic                         ERROR,
  output logic [2:0]                   ERR_CODE
);

  localparam int KEEP_W = int'(C_TDATA_WIDTH / 8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Number of bytes qualified by a TKEEP vector.
  function automatic logic [31:0] keep_popcount(input logic [KEEP_W-1:0] keep);
    logic [31:0] cnt;
    cnt = 32'd0;
    for (int i = 0; i < KEEP_W; i++) begin
      cnt = cnt + {31'd0, keep[i]};
    end
    return cnt;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_next_s;
  logic        lfsr_fb_s;
  logic        tready_r;
  logic        tready_next_s;
  logic        done_r;
  logic [31:0] pkt_count_r;
  logic [31:0] byte_count_r;
  logic [31:0] pkt_inc_s;
  logic        accept_s;
  logic        last_accept_s;

  // Handshake decode and the packet count that a TLAST beat would produce.
  always_comb begin
    accept_s      = S_AXIS_TVALID & tready_r;
    last_accept_s = accept_s & S_AXIS_TLAST;
    pkt_inc_s     = pkt_count_r + 32'd1;
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_RECV: begin
        if (last_accept_s) begin
          // The packet that reaches the target count ends the run for good.
          if (pkt_inc_s == C_NUM_PACKETS) begin
            state_next_s = ST_FIN;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else if (accept_s) begin
          state_next_s = ST_RECV;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_FIN: begin
        state_next_s = ST_FIN;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // LFSR advance (taps 16,14,13,11, shifting towards bit 0). It freezes once FIN is reached.
  always_comb begin
    lfsr_fb_s = lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5];
    if (state_r == ST_FIN) begin
      lfsr_next_s = lfsr_r;
    end else begin
      lfsr_next_s = {lfsr_fb_s, lfsr_r[15:1]};
    end
  end

  // TREADY is registered from next-cycle values.
  // It therefore always equals lfsr[0] (or 1), gated off in FIN.
  always_comb begin
    if (state_next_s == ST_FIN) begin
      tready_next_s = 1'b0;
    end else if (C_BACKPRESSURE != 32'd0) begin
      tready_next_s = lfsr_next_s[0];
    end else begin
      tready_next_s = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // LFSR, TREADY, DONE and the packet/byte counters.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      lfsr_r       <= C_LFSR_SEED;
      tready_r     <= 1'b0;
      done_r       <= 1'b0;
      pkt_count_r  <= 32'd0;
      byte_count_r <= 32'd0;
    end else begin
      lfsr_r   <= lfsr_next_s;
      tready_r <= tready_next_s;
      done_r   <= (state_next_s == ST_FIN);
      if (last_accept_s) begin
        pkt_count_r <= pkt_inc_s;
      end
      if (accept_s) begin
        byte_count_r <= byte_count_r + keep_popcount(S_AXIS_TKEEP);
      end
    end
  end

  assign S_AXIS_TREADY = tready_r;
  assign DONE          = done_r;
  assign PKT_COUNT     = pkt_count_r;
  assign BYTE_COUNT    = byte_count_r;

`ifdef NET2AXIS_SINK_CHECK_EN

  // True when TKEEP is nonzero and of the form ones-from-LSB.
  function automatic logic keep_is_contiguous(input logic [KEEP_W-1:0] keep);
    logic [KEEP_W-1:0] plus_one;
    plus_one = keep + KEEP_W'(1'b1);
    return (keep != {KEEP_W{1'b0}}) && ((keep & plus_one) == {KEEP_W{1'b0}});
  endfunction

  logic                     stall_r;
  logic [C_TDATA_WIDTH-1:0] hold_data_r;
  logic [KEEP_W-1:0]        hold_keep_r;
  logic                     hold_last_r;
  logic [2:0]               err_code_r;
  logic                     error_r;
  logic [2:0]               err_set_s;

  // Protocol violations detected at this edge.
  always_comb begin
    err_set_s = 3'b000;
    // A beat stalled on the previous edge must be held unchanged.
    if (stall_r && (!S_AXIS_TVALID || (S_AXIS_TDATA != hold_data_r) ||
                    (S_AXIS_TKEEP != hold_keep_r) || (S_AXIS_TLAST != hold_last_r))) begin
      err_set_s[0] = 1'b1;
    end else begin
      err_set_s[0] = 1'b0;
    end
    if (accept_s && !keep_is_contiguous(S_AXIS_TKEEP)) begin
      err_set_s[1] = 1'b1;
    end else begin
      err_set_s[1] = 1'b0;
    end
    if (accept_s && !S_AXIS_TLAST && !(&S_AXIS_TKEEP)) begin
      err_set_s[2] = 1'b1;
    end else begin
      err_set_s[2] = 1'b0;
    end
  end

  // Capture stalled beats for the stability check and accumulate sticky flags.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stall_r     <= 1'b0;
      hold_data_r <= {C_TDATA_WIDTH{1'b0}};
      hold_keep_r <= {KEEP_W{1'b0}};
      hold_last_r <= 1'b0;
      err_code_r  <= 3'b000;
      error_r     <= 1'b0;
    end else begin
      stall_r     <= S_AXIS_TVALID & ~tready_r;
      hold_data_r <= S_AXIS_TDATA;
      hold_keep_r <= S_AXIS_TKEEP;
      hold_last_r <= S_AXIS_TLAST;
      err_code_r  <= err_code_r | err_set_s;
      error_r     <= |(err_code_r | err_set_s);
    end
  end

  assign ERR_CODE = err_code_r;
  assign ERROR    = error_r;

`else

  // TDATA has no function without the checker.
  logic unused_tdata_s;
  assign unused_tdata_s = ^S_AXIS_TDATA;

  assign ERR_CODE = 3'b000;
  assign ERROR    = 1'b0;

`endif

endmodule

// File: tb/tb_net2axis_sink.sv
// Bench for net2axis_sink.
// dut_a: two packets, no backpressure. Checked with a vector table and short
//        hand-written sequences.
// dut_b: LFSR backpressure. Checked against a behavioural packet/byte/LFSR model.
module tb_net2axis_sink;

  localparam logic [31:0] B_NPKT = 32'd12;
  localparam logic [15:0] SEED   = 16'hACE1;
`ifdef NET2AXIS_SINK_CHECK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_valid, a_last, a_ready, a_done, a_error;
  logic [31:0] a_data, a_pkt, a_bytes;
  logic [3:0]  a_keep;
  logic [2:0]  a_err;
  logic        b_rst, b_valid, b_last, b_ready, b_done, b_error;
  logic [31:0] b_data, b_pkt, b_bytes;
  logic [3:0]  b_keep;
  logic [2:0]  b_err;

  net2axis_sink #(.C_TDATA_WIDTH(32), .C_NUM_PACKETS(32'd2), .C_BACKPRESSURE(0),
                  .C_LFSR_SEED(SEED)) dut_a (
    .ACLK(clk), .ARESET(a_rst), .S_AXIS_TVALID(a_valid), .S_AXIS_TDATA(a_data),
    .S_AXIS_TKEEP(a_keep), .S_AXIS_TLAST(a_last), .S_AXIS_TREADY(a_ready),
    .DONE(a_done), .PKT_COUNT(a_pkt), .BYTE_COUNT(a_bytes), .ERROR(a_error),
    .ERR_CODE(a_err));

  net2axis_sink #(.C_TDATA_WIDTH(32), .C_NUM_PACKETS(B_NPKT), .C_BACKPRESSURE(1),
                  .C_LFSR_SEED(SEED)) dut_b (
    .ACLK(clk), .ARESET(b_rst), .S_AXIS_TVALID(b_valid), .S_AXIS_TDATA(b_data),
    .S_AXIS_TKEEP(b_keep), .S_AXIS_TLAST(b_last), .S_AXIS_TREADY(b_ready),
    .DONE(b_done), .PKT_COUNT(b_pkt), .BYTE_COUNT(b_bytes), .ERROR(b_error),
    .ERR_CODE(b_err));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic a_check(input string tag, input logic rdy, input logic [31:0] pkt,
                         input logic [31:0] bytes, input logic done, input logic [2:0] err);
    chk({tag, ".tready"}, 32'(a_ready), 32'(rdy));
    chk({tag, ".pkt"},    a_pkt, pkt);
    chk({tag, ".bytes"},  a_bytes, bytes);
    chk({tag, ".done"},   32'(a_done), 32'(done));
    chk({tag, ".errcode"}, 32'(a_err), 32'(err));
    chk({tag, ".error"},  32'(a_error), 32'(|err));
  endtask

  task automatic a_drive(input logic v, input logic [3:0] k, input logic l, input logic [31:0] d);
    a_valid = v; a_keep = k; a_last = l; a_data = d;
  endtask

  task automatic a_step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset on dut_a, check the in-reset state, then release and let TREADY rise.
  task automatic a_pulse_reset(input string tag);
    a_rst = 1'b1;
    a_drive(1'b0, 4'h0, 1'b0, 32'd0);
    a_step();
    a_check({tag, ".inrst"}, 1'b0, 32'd0, 32'd0, 1'b0, 3'b000);
    a_rst = 1'b0;
    a_step();
    a_check({tag, ".released"}, 1'b1, 32'd0, 32'd0, 1'b0, 3'b000);
  endtask

  // ---------------- behavioural model for dut_b ----------------
  logic [15:0] m_lfsr;
  logic        m_ready, m_fin, m_acc, m_stall, m_pl;
  logic [31:0] m_pkts, m_bytes, m_pd;
  logic [3:0]  m_pk;
  logic [2:0]  m_err;
  int          b_cyc = 0;

  // Polynomial x^16+x^14+x^13+x^11+1 as integer arithmetic.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    int v, fb;
    v  = int'(s);
    fb = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
    return 16'((v >> 1) | (fb << 15));
  endfunction

  function automatic bit keep_legal(input logic [3:0] k);
    return k inside {4'b0001, 4'b0011, 4'b0111, 4'b1111};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_ready = 1'b0; m_fin = 1'b0; m_acc = 1'b0; m_stall = 1'b0;
    m_pkts = 32'd0; m_bytes = 32'd0; m_err = 3'b000;
    m_pd = 32'd0; m_pk = 4'h0; m_pl = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] k, input logic l, input logic [31:0] d);
    bit was_fin;
    m_acc = v && m_ready;
    if (CHK_ON) begin
      if (m_stall && (!v || d != m_pd || k != m_pk || l != m_pl)) m_err[0] = 1'b1;
      if (m_acc && !keep_legal(k)) m_err[1] = 1'b1;
      if (m_acc && !l && k != 4'hF) m_err[2] = 1'b1;
    end
    m_stall = v && !m_ready;
    m_pd = d; m_pk = k; m_pl = l;
    was_fin = m_fin;
    if (m_acc) begin
      m_bytes = m_bytes + 32'($countones(k));
      if (l) begin
        m_pkts = m_pkts + 32'd1;
        if (m_pkts == B_NPKT) m_fin = 1'b1;
      end
    end
    if (!was_fin) m_lfsr = lfsr_step(m_lfsr);
    m_ready = !m_fin && m_lfsr[0];
  endtask

  task automatic b_cycle(input logic v, input logic [3:0] k, input logic l, input logic [31:0] d);
    b_valid = v; b_keep = k; b_last = l; b_data = d;
    @(posedge clk);
    model_edge(v, k, l, d);
    #1;
    b_cyc++;
    chk($sformatf("b%0d.tready", b_cyc), 32'(b_ready), 32'(m_ready));
    chk($sformatf("b%0d.pkt", b_cyc), b_pkt, m_pkts);
    chk($sformatf("b%0d.bytes", b_cyc), b_bytes, m_bytes);
    chk($sformatf("b%0d.done", b_cyc), 32'(b_done), 32'(m_fin));
    chk($sformatf("b%0d.errcode", b_cyc), 32'(b_err), 32'(m_err));
    chk($sformatf("b%0d.error", b_cyc), 32'(b_error), 32'(|m_err));
  endtask

  task automatic b_reset();
    b_rst = 1'b1;
    b_valid = 1'b0; b_keep = 4'h0; b_last = 1'b0; b_data = 32'd0;
    @(posedge clk);
    #1;
    chk("b.inrst.tready", 32'(b_ready), 32'd0);
    chk("b.inrst.bytes", b_bytes, 32'd0);
    b_rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table for dut_a ----------------
  typedef struct {
    logic        valid;
    logic [3:0]  keep;
    logic        last;
    logic [31:0] data;
    logic        rdy;
    logic [31:0] pkt;
    logic [31:0] bytes;
    logic        done;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  keep_pool [8];
    logic        rv, rl;
    logic [3:0]  rk;
    logic [31:0] rd, d;
    int          beats, cyc;

    keep_pool = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h7, 4'h3, 4'h1, 4'h5};

    // Packet 1: three full beats then a two-byte tail; packet 2: one full beat.
    tbl[0] = '{1'b0, 4'h0, 1'b0, 32'h0000_0000, 1'b1, 32'd0, 32'd0,  1'b0};
    tbl[1] = '{1'b1, 4'hF, 1'b0, 32'h1111_1111, 1'b1, 32'd0, 32'd4,  1'b0};
    tbl[2] = '{1'b1, 4'hF, 1'b0, 32'h2222_2222, 1'b1, 32'd0, 32'd8,  1'b0};
    tbl[3] = '{1'b1, 4'hF, 1'b0, 32'h3333_3333, 1'b1, 32'd0, 32'd12, 1'b0};
    tbl[4] = '{1'b1, 4'h3, 1'b1, 32'h4444_4444, 1'b1, 32'd1, 32'd14, 1'b0};
    tbl[5] = '{1'b1, 4'hF, 1'b1, 32'h5555_5555, 1'b0, 32'd2, 32'd18, 1'b1};
    // Beats offered in FIN are refused and held stable.
    tbl[6] = '{1'b1, 4'hF, 1'b1, 32'h600D_F00D, 1'b0, 32'd2, 32'd18, 1'b1};
    tbl[7] = '{1'b1, 4'hF, 1'b1, 32'h600D_F00D, 1'b0, 32'd2, 32'd18, 1'b1};

    a_rst = 1'b1; b_rst = 1'b1;
    a_drive(1'b0, 4'h0, 1'b0, 32'd0);
    b_valid = 1'b0; b_keep = 4'h0; b_last = 1'b0; b_data = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    a_check("reset", 1'b0, 32'd0, 32'd0, 1'b0, 3'b000);
    a_rst = 1'b0;
    #1;
    chk("a.tready_before_edge", 32'(a_ready), 32'd0);

    for (int i = 0; i < 8; i++) begin
      a_drive(tbl[i].valid, tbl[i].keep, tbl[i].last, tbl[i].data);
      a_step();
      a_check($sformatf("tbl%0d", i), tbl[i].rdy, tbl[i].pkt, tbl[i].bytes, tbl[i].done, 3'b000);
    end

    // TVALID dropped while TREADY=0 (stalled in FIN).
    a_drive(1'b0, 4'hF, 1'b1, 32'h600D_F00D);
    a_step();
    a_check("stab_drop", 1'b0, 32'd2, 32'd18, 1'b1, CHK_ON ? 3'b001 : 3'b000);
    repeat (3) a_step();
    a_check("stab_sticky", 1'b0, 32'd2, 32'd18, 1'b1, CHK_ON ? 3'b001 : 3'b000);

    // TKEEP rules: partial non-last beat, then a gapped last beat.
    a_pulse_reset("rst1");
    a_drive(1'b1, 4'h7, 1'b0, 32'hAAAA_0001);
    a_step();
    a_check("keep_partial", 1'b1, 32'd0, 32'd3, 1'b0, CHK_ON ? 3'b100 : 3'b000);
    a_drive(1'b1, 4'h5, 1'b1, 32'hAAAA_0002);
    a_step();
    a_check("keep_gap", 1'b1, 32'd1, 32'd5, 1'b0, CHK_ON ? 3'b110 : 3'b000);
    a_drive(1'b0, 4'h0, 1'b0, 32'd0);

    // Reset in the middle of a packet, then a clean 4-beat packet.
    a_pulse_reset("rst2");
    for (int i = 0; i < 2; i++) begin
      a_drive(1'b1, 4'hF, 1'b0, 32'(i));
      a_step();
    end
    a_check("mid_pkt", 1'b1, 32'd0, 32'd8, 1'b0, 3'b000);
    a_pulse_reset("rst3");
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b1, 4'hF, (i == 3), 32'(i + 16));
      a_step();
    end
    a_drive(1'b0, 4'h0, 1'b0, 32'd0);
    a_check("after_reset_pkt", 1'b1, 32'd1, 32'd16, 1'b0, 3'b000);

    // 64-beat packet under LFSR backpressure.
    b_reset();
    beats = 0; cyc = 0; d = $urandom;
    while (beats < 64 && cyc < 2000) begin
      b_cycle(1'b1, 4'hF, (beats == 63), d);
      if (m_acc) begin
        beats++;
        d = $urandom;
      end
      cyc++;
    end
    chk("lfsr_pkt.beats_in_budget", 32'(beats), 32'd64);
    chk("lfsr_pkt.bytes", b_bytes, 32'd256);
    chk("lfsr_pkt.pkt", b_pkt, 32'd1);
    chk("lfsr_pkt.error", 32'(b_error), 32'd0);

    // Randomised traffic: mostly holds stalled beats, occasionally breaks the rules.
    rv = 1'b0; rk = 4'h0; rl = 1'b0; rd = 32'd0;
    for (int r = 0; r < 3; r++) begin
      b_reset();
      for (int c = 0; c < 200; c++) begin
        if (!(m_stall && $urandom_range(9, 0) != 0)) begin
          rv = ($urandom_range(3, 0) != 0);
          rk = keep_pool[$urandom_range(7, 0)];
          if ($urandom_range(15, 0) == 0) rk = 4'h0;
          rl = ($urandom_range(2, 0) == 0);
          rd = $urandom;
        end
        b_cycle(rv, rk, rl, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
